load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the CPU execute stage and the Memory block; converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into Memory's word-addressed strobe/mask interface.
- Aligns store data and byte masks, absorbs Memory's one-cycle registered read latency, and extracts and sign/zero-extends load data.
- Returns one response per request over a valid/ready handshake; misaligned, out-of-range or illegal accesses get an error response and never touch memory.

Parameters:
- MEM_BYTES, 4096, size of the backing Memory in bytes (1024 words); byte addresses >= MEM_BYTES fault.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  CPU presents a request
- req_ready  out  1  unit can accept; equals (state==IDLE)
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32I funct3 (size/sign)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  response available
- rsp_ready  in  1  CPU consumes response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  request faulted (misaligned/out-of-range/illegal funct3)
- mem_addr  out  32  byte address to Memory (registered)
- mem_rstrb  out  1  read strobe to Memory (registered)
- mem_wdata  out  32  lane-replicated store data (registered)
- mem_wmask  out  4  byte write enables (registered)
- mem_rdata  in  32  Memory read data, valid the cycle after the strobe edge

Behaviour:
- Reset: async to IDLE; req_ready=1 after reset release; rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_addr=0, mem_rstrb=0, mem_wdata=0, mem_wmask=0. Reset mid-transaction drops it and immediately deasserts mem_wmask/mem_rstrb; no response is produced.
- States: IDLE, ISSUE, RDWAIT, RESP.
- IDLE: on req_valid (req_ready=1), capture the request at edge E0.
  - Fault: go to RESP with rsp_err=1 and rsp_rdata=0; no strobe, no mask.
  - Otherwise: go to ISSUE, loading mem_addr=req_addr and either mem_rstrb=1 (load) or mem_wmask/mem_wdata (store).
- Fault conditions:
  - funct3 not in {000,001,010,100,101} for loads, or not in {000,001,010} for stores.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - addr >= MEM_BYTES.
- Store formatting:
  - SB: wdata={4{b[7:0]}}, wmask=4'b0001<<addr[1:0].
  - SH: wdata={2{h[15:0]}}, wmask=4'b0011<<{addr[1],1'b0}.
  - SW: wdata as given, wmask=4'b1111.
- ISSUE lasts exactly one cycle; Memory samples at edge E1. At E1 mem_rstrb and mem_wmask clear to 0; mem_addr and mem_wdata hold.
  - Store: go to RESP (rsp_valid after E1).
  - Load: go to RDWAIT.
- RDWAIT: one cycle. At E2, register the extracted load data into rsp_rdata and go to RESP.
  - Select the byte lane by addr[1:0] and the halfword by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Latency from accept edge: store or fault response visible after E1 (fault after E0); load response after E2.
- RESP: rsp_valid=1 and rsp_rdata/rsp_err stable until rsp_valid&&rsp_ready. On that edge rsp_valid=0, rsp_err=0, rsp_rdata=0, state IDLE. No new request is accepted in the same cycle (req_ready=0 in RESP).
- Exactly one mem_rstrb or one nonzero mem_wmask pulse per non-faulting request; never both.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> mem_wmask=4'b1111 for one cycle; load rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid two edges after ISSUE edge.
- SB 0x13 data 0x000000A5, then LB 0x13 and LBU 0x13 -> wmask=4'b1000, mem_wdata=0xA5A5A5A5; LB=0xFFFFFFA5, LBU=0x000000A5; other bytes of the word unchanged.
- SH 0x22 data 0x8001, then LH/LHU 0x22 -> wmask=4'b1100; LH=0xFFFF8001, LHU=0x00008001.
- LW 0x12, SH 0x11, LB with funct3=011, LW 0x1000 -> each rsp_err=1, rsp_rdata=0; no mem_rstrb and mem_wmask=0 throughout.
- Hold rsp_ready=0 for 5 cycles after a load of 0x12345678 -> rsp_valid and rsp_rdata stable; req_ready=0; next request accepted only after the handshake edge.
- Assert reset during ISSUE of a SW -> mem_wmask drops to 0 immediately; all outputs at reset values; req_ready=1 after release; no stale rsp_valid.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store front end for a word-addressed memory with one-cycle registered reads.
// Formats stores into byte masks, extends loads, and answers every request over valid/ready.
module load_store_unit #(
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic        mem_rstrb,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata
);

    // state | meaning: IDLE accept | ISSUE strobe/mask out | RDWAIT capture load | RESP hold response
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
    localparam logic [1:0] RDWAIT = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_BYTES);

    logic [1:0]  state;
    logic [2:0]  funct3_q;

    logic        f3_ok;
    logic        align_ok;
    logic        range_ok;
    logic        fault;
    logic [31:0] st_wdata;
    logic [3:0]  st_wmask;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    always_comb begin
        f3_ok = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = !req_we;
            default:                f3_ok = 1'b0;
        endcase
    end

    always_comb begin
        align_ok = 1'b1;
        case (req_funct3[1:0])
            2'b01:   align_ok = !req_addr[0];
            2'b10:   align_ok = (req_addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
    end

    assign range_ok = (req_addr < ADDR_LIMIT);
    assign fault    = !(f3_ok && align_ok && range_ok);

    // Replicate store data across lanes so Memory only needs the mask to pick bytes.
    always_comb begin
        st_wdata = req_wdata;
        st_wmask = 4'b1111;
        case (req_funct3[1:0])
            2'b00: begin
                st_wdata = {4{req_wdata[7:0]}};
                st_wmask = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{req_wdata[15:0]}};
                st_wmask = 4'b0011 << {req_addr[1], 1'b0};
            end
            default: begin
                st_wdata = req_wdata;
                st_wmask = 4'b1111;
            end
        endcase
    end

    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (mem_addr[1:0])
            2'b00:   ld_byte = mem_rdata[7:0];
            2'b01:   ld_byte = mem_rdata[15:8];
            2'b10:   ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
    end

    assign ld_half = mem_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        ld_data = mem_rdata;
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            funct3_q  <= 3'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            mem_addr  <= 32'd0;
            mem_rstrb <= 1'b0;
            mem_wdata <= 32'd0;
            mem_wmask <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        funct3_q <= req_funct3;
                        if (fault) begin
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                            state     <= RESP;
                        end else begin
                            mem_addr <= req_addr;
                            if (req_we) begin
                                mem_wmask <= st_wmask;
                                mem_wdata <= st_wdata;
                            end else begin
                                mem_rstrb <= 1'b1;
                            end
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    mem_rstrb <= 1'b0;
                    mem_wmask <= 4'd0;
                    // the strobe itself tells us whether this was a load
                    state     <= mem_rstrb ? RDWAIT : RESP;
                end
                RDWAIT: begin
                    rsp_rdata <= ld_data;
                    state     <= RESP;
                end
                default: begin
                    if (rsp_ready) begin
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 32'd0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory and a response scoreboard.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem [0:1023];
    int          total = 0;
    int          bad = 0;
    int          rstrb_cnt = 0;
    int          wmask_cnt = 0;
    int          both_cnt = 0;
    logic [3:0]  last_wmask = 4'd0;
    logic [31:0] last_wdata = 32'd0;

    load_store_unit #(.MEM_BYTES(4096)) dut (
        .clk       (clk),
        .reset     (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_rstrb (mem_rstrb),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: registered read, byte-masked write, plus pulse bookkeeping.
    always @(posedge clk) begin
        if (mem_rstrb) begin
            mem_rdata <= mem[mem_addr[11:2]];
            rstrb_cnt++;
        end
        if (mem_wmask != 4'd0) begin
            for (int i = 0; i < 4; i++)
                if (mem_wmask[i]) mem[mem_addr[11:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
            wmask_cnt++;
            last_wmask = mem_wmask;
            last_wdata = mem_wdata;
        end
        if (mem_rstrb && mem_wmask != 4'd0) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_err, input logic [31:0] exp_rdata,
                          input logic [3:0] exp_wmask, input logic [31:0] exp_wdata,
                          input int hold);
        int   rs0;
        int   wm0;
        int   lat;
        int   exp_lat;
        bit   seen;
        exp_t e;
        rs0     = rstrb_cnt;
        wm0     = wmask_cnt;
        exp_lat = exp_err ? 1 : (we ? 2 : 3);
        @(negedge clk);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        sb_q.push_back('{exp_err, exp_rdata});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rsp_ready = (hold == 0);
        lat  = 0;
        seen = 0;
        while (!seen && lat < 10) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) seen = 1;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        e = sb_q.pop_front();
        if (seen) begin
            chk({tag, "_err"}, 32'(rsp_err), 32'(e.err));
            chk({tag, "_rdata"}, rsp_rdata, e.rdata);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "_hold_rdata"}, rsp_rdata, e.rdata);
            chk({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_post_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_post_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_post_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rstrb_pulses"}, 32'(rstrb_cnt - rs0), (!exp_err && !we) ? 32'd1 : 32'd0);
        chk({tag, "_wmask_pulses"}, 32'(wmask_cnt - wm0), (!exp_err && we) ? 32'd1 : 32'd0);
        if (!exp_err && we) begin
            chk({tag, "_wmask"}, 32'(last_wmask), 32'(exp_wmask));
            chk({tag, "_wdata"}, last_wdata, exp_wdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem_rdata  = 32'd0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        rsp_ready  = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_mem_rstrb", 32'(mem_rstrb), 32'd0);
        chk("reset_mem_wdata", mem_wdata, 32'd0);
        chk("reset_mem_wmask", 32'(mem_wmask), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);

        //     tag        we    f3      addr          wdata         err   rdata          wmask    wdata          hold
        do_req("sw_10",   1'b1, 3'b010, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0,         4'b1111, 32'hDEADBEEF, 0);
        do_req("lw_10",   1'b0, 3'b010, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF,  4'b0000, 32'h0,        0);
        do_req("sb_13",   1'b1, 3'b000, 32'h13,       32'h000000A5, 1'b0, 32'h0,         4'b1000, 32'hA5A5A5A5, 0);
        do_req("lb_13",   1'b0, 3'b000, 32'h13,       32'h0,        1'b0, 32'hFFFFFFA5,  4'b0000, 32'h0,        0);
        do_req("lbu_13",  1'b0, 3'b100, 32'h13,       32'h0,        1'b0, 32'h000000A5,  4'b0000, 32'h0,        0);
        do_req("lw_10b",  1'b0, 3'b010, 32'h10,       32'h0,        1'b0, 32'hA5ADBEEF,  4'b0000, 32'h0,        0);
        do_req("sh_22",   1'b1, 3'b001, 32'h22,       32'h00008001, 1'b0, 32'h0,         4'b1100, 32'h80018001, 0);
        do_req("lh_22",   1'b0, 3'b001, 32'h22,       32'h0,        1'b0, 32'hFFFF8001,  4'b0000, 32'h0,        0);
        do_req("lhu_22",  1'b0, 3'b101, 32'h22,       32'h0,        1'b0, 32'h00008001,  4'b0000, 32'h0,        0);
        do_req("lw_20",   1'b0, 3'b010, 32'h20,       32'h0,        1'b0, 32'h80010000,  4'b0000, 32'h0,        0);
        do_req("f_lw_12", 1'b0, 3'b010, 32'h12,       32'h0,        1'b1, 32'h0,         4'b0000, 32'h0,        0);
        do_req("f_sh_11", 1'b1, 3'b001, 32'h11,       32'h1234,     1'b1, 32'h0,         4'b0000, 32'h0,        0);
        do_req("f_f3_011",1'b0, 3'b011, 32'h10,       32'h0,        1'b1, 32'h0,         4'b0000, 32'h0,        0);
        do_req("f_lw_1000",1'b0,3'b010, 32'h1000,     32'h0,        1'b1, 32'h0,         4'b0000, 32'h0,        0);
        do_req("f_st_100",1'b1, 3'b100, 32'h10,       32'h55,       1'b1, 32'h0,         4'b0000, 32'h0,        0);
        do_req("f_lh_21", 1'b0, 3'b001, 32'h21,       32'h0,        1'b1, 32'h0,         4'b0000, 32'h0,        0);
        do_req("sw_30",   1'b1, 3'b010, 32'h30,       32'h12345678, 1'b0, 32'h0,         4'b1111, 32'h12345678, 0);
        do_req("lw_30_hold",1'b0,3'b010,32'h30,       32'h0,        1'b0, 32'h12345678,  4'b0000, 32'h0,        5);
        do_req("lb_31",   1'b0, 3'b000, 32'h31,       32'h0,        1'b0, 32'h00000056,  4'b0000, 32'h0,        0);
        do_req("lh_32",   1'b0, 3'b001, 32'h32,       32'h0,        1'b0, 32'h00001234,  4'b0000, 32'h0,        0);
        do_req("lbu_30",  1'b0, 3'b100, 32'h30,       32'h0,        1'b0, 32'h00000078,  4'b0000, 32'h0,        0);
        do_req("sw_ffc",  1'b1, 3'b010, 32'hFFC,      32'hCAFEF00D, 1'b0, 32'h0,         4'b1111, 32'hCAFEF00D, 0);
        do_req("lw_ffc",  1'b0, 3'b010, 32'hFFC,      32'h0,        1'b0, 32'hCAFEF00D,  4'b0000, 32'h0,        0);
        do_req("sb_31",   1'b1, 3'b000, 32'h31,       32'h000000FF, 1'b0, 32'h0,         4'b0010, 32'hFFFFFFFF, 0);
        do_req("lw_30b",  1'b0, 3'b010, 32'h30,       32'h0,        1'b0, 32'h1234FF78,  4'b0000, 32'h0,        0);

        // Reset while a store sits in ISSUE: the mask must vanish before Memory samples it.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h40;
        req_wdata  = 32'h55AA55AA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("rst_issue_wmask", 32'(mem_wmask), 32'hF);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_wmask", 32'(mem_wmask), 32'd0);
        chk("rst_mid_rstrb", 32'(mem_rstrb), 32'd0);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_mem_addr", mem_addr, 32'd0);
        chk("rst_mid_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_after_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_after_req_ready", 32'(req_ready), 32'd1);
        end
        do_req("lw_40",   1'b0, 3'b010, 32'h40,       32'h0,        1'b0, 32'h0,         4'b0000, 32'h0,        0);
        chk("never_both", 32'(both_cnt), 32'd0);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
